gf_mul_tower_pipe: RTL and testbench

Fully pipelined GF(2^8) / GF(2^16) / GF(2^32) tower-field multiplier with valid/ready streaming and tag passthrough. It accepts one operand pair per cycle, has a fixed latency, and stalls cleanly under backpressure. It replaces the single-shot 16-bit start/done multiplier in the SDitH arithmetic datapath (MPC share evaluation, polynomial products), where back-to-back products must not wait for a done pulse.

---
 rtl/gf_tower_pkg.sv | 49 ++++
 rtl/gf_mul_8.sv | 30 +++
 rtl/gf_mul_tower_pipe.sv | 197 +++++++++++++++++++
 tb/tb_gf_mul_tower_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_tower_pkg.sv
// ---------------------------------------------------------------------------
// gf_tower_pkg
// Shared constants and types for the GF(2^8)/GF(2^16)/GF(2^32) tower-field
// multiplier.
//   GF8_POLY    : low byte of the GF(2^8) reduction polynomial 0x11B
//   CST_GF2P16  : C for GF(2^16) = GF(2^8)[X]/(X^2+X+C)
//   CST_GF2P32  : C for GF(2^32) = GF(2^16)[Y]/(Y^2+Y+C)
//   SUBP        : sub-products per tower level (3 when GF_MUL_KARATSUBA_EN
//                 is defined, 4 otherwise)
//   gf_lat()    : pipeline latency for a given WIDTH (0 = illegal width)
// ---------------------------------------------------------------------------
package gf_tower_pkg;

    localparam logic [7:0]  GF8_POLY   = 8'h1B;
    localparam logic [7:0]  CST_GF2P16 = 8'h20;
    localparam logic [15:0] CST_GF2P32 = 16'h2000;

`ifdef GF_MUL_KARATSUBA_EN
    localparam int SUBP = 3;
`else
    localparam int SUBP = 4;
`endif

    // Level-a register contents of one tower level: the low product, the
    // constant-multiplied high product, and two terms whose XOR is r1.
    typedef struct packed {
        logic [7:0] lo;
        logic [7:0] cm;
        logic [7:0] x1;
        logic [7:0] x2;
    } lvl16_t;

    typedef struct packed {
        logic [15:0] lo;
        logic [15:0] cm;
        logic [15:0] x1;
        logic [15:0] x2;
    } lvl32_t;

    function automatic int gf_lat(input int width);
        case (width)
            8:       return 2;
            16:      return 4;
            32:      return 6;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/gf_mul_8.sv
// ---------------------------------------------------------------------------
// gf_mul_8
// Purely combinational GF(2^8) multiplier, reduction polynomial 0x11B.
//   i_a, i_b : operands
//   o_p      : product i_a * i_b
// ---------------------------------------------------------------------------
module gf_mul_8
    import gf_tower_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_p
);

    logic [7:0] w_acc;
    logic [7:0] w_sh;

    // Shift-and-add: w_sh walks through i_a * x^i, reduced at each step.
    always_comb begin
        w_acc = '0;
        w_sh  = i_a;
        for (int i = 0; i < 8; i++) begin
            if (i_b[i]) w_acc = w_acc ^ w_sh;
            w_sh = {w_sh[6:0], 1'b0} ^ (w_sh[7] ? GF8_POLY : 8'h00);
        end
    end

    assign o_p = w_acc;

endmodule

// File: rtl/gf_mul_tower_pipe.sv
// ---------------------------------------------------------------------------
// gf_mul_tower_pipe
// Fully pipelined GF(2^8)/GF(2^16)/GF(2^32) tower-field multiplier with a
// valid/ready stream and a sideband tag. One product per cycle, fixed
// latency (2/4/6 for WIDTH 8/16/32), single global stall enable.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_valid/o_ready: input handshake, operands i_x, i_y, tag i_tag
//   o_valid/i_ready: output handshake, product o_o, tag o_tag
// Build option: GF_MUL_KARATSUBA_EN selects 3 sub-products per tower level
// instead of 4; results and timing are identical.
// Stages: 0 input reg, 1 GF(2^8) sub-products, then per tower level
// (a) constant multiply + partial XOR and (b) final combine.
// ---------------------------------------------------------------------------
module gf_mul_tower_pipe
    import gf_tower_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_o,
    output logic [TAG_W-1:0] o_tag
);

    localparam int LAT = (gf_lat(WIDTH) < 2) ? 2 : gf_lat(WIDTH);

    if (gf_lat(WIDTH) == 0) begin : g_bad_width
        $error("gf_mul_tower_pipe: WIDTH must be 8, 16 or 32");
    end

    logic                      w_en;
    logic [LAT-1:0]            r_vld_pipe;
    logic [LAT-1:0][TAG_W-1:0] r_tag_pipe;
    logic [WIDTH-1:0]          r_x;
    logic [WIDTH-1:0]          r_y;

    // Every stage moves together; bubbles are not squeezed out on stall.
    assign w_en    = ~r_vld_pipe[LAT-1] | i_ready;
    assign o_ready = w_en;
    assign o_valid = r_vld_pipe[LAT-1];
    assign o_tag   = r_tag_pipe[LAT-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_pipe <= '0;
            r_tag_pipe <= '0;
            r_x        <= '0;
            r_y        <= '0;
        end else if (w_en) begin
            r_vld_pipe <= {r_vld_pipe[LAT-2:0], i_valid};
            r_tag_pipe <= {r_tag_pipe[LAT-2:0], i_tag};
            r_x        <= i_x;
            r_y        <= i_y;
        end
    end

    if (WIDTH == 8) begin : g_w8
        logic [7:0] w_p;
        logic [7:0] r_p;

        gf_mul_8 u_mul (.i_a(r_x), .i_b(r_y), .o_p(w_p));

        always_ff @(posedge i_clk) begin
            if (i_rst)     r_p <= '0;
            else if (w_en) r_p <= w_p;
        end

        assign o_o = r_p;
    end else begin : g_tower
        // Number of GF(2^16) products feeding the top level.
        localparam int NP16 = (WIDTH == 32) ? SUBP : 1;

        logic [NP16-1:0][15:0]           w_u;
        logic [NP16-1:0][15:0]           w_v;
        logic [NP16-1:0][SUBP-1:0][7:0]  w_p8;
        logic [NP16-1:0][SUBP-1:0][7:0]  r_p8;
        lvl16_t [NP16-1:0]               w_s2;
        lvl16_t [NP16-1:0]               r_s2;
        logic [NP16-1:0][15:0]           w_s3;
        logic [NP16-1:0][15:0]           r_s3;

        // Operand pairs of the GF(2^16) products.
        // Index order: 0 = A0B0, 1 = A1B1, 2 = mid or A0B1, 3 = A1B0.
        if (WIDTH == 16) begin : g_op16
            assign w_u[0] = r_x;
            assign w_v[0] = r_y;
        end else begin : g_op32
            assign w_u[0] = r_x[15:0];
            assign w_v[0] = r_y[15:0];
            assign w_u[1] = r_x[31:16];
            assign w_v[1] = r_y[31:16];
`ifdef GF_MUL_KARATSUBA_EN
            assign w_u[2] = r_x[15:0] ^ r_x[31:16];
            assign w_v[2] = r_y[15:0] ^ r_y[31:16];
`else
            assign w_u[2] = r_x[15:0];
            assign w_v[2] = r_y[31:16];
            assign w_u[3] = r_x[31:16];
            assign w_v[3] = r_y[15:0];
`endif
        end

        for (genvar k = 0; k < NP16; k++) begin : g_p16
            logic [SUBP-1:0][7:0] w_a;
            logic [SUBP-1:0][7:0] w_b;
            logic [7:0]           w_cm;

            always_comb begin
                w_a    = '0;
                w_b    = '0;
                w_a[0] = w_u[k][7:0];
                w_b[0] = w_v[k][7:0];
                w_a[1] = w_u[k][15:8];
                w_b[1] = w_v[k][15:8];
`ifdef GF_MUL_KARATSUBA_EN
                w_a[2] = w_u[k][7:0] ^ w_u[k][15:8];
                w_b[2] = w_v[k][7:0] ^ w_v[k][15:8];
`else
                w_a[2] = w_u[k][7:0];
                w_b[2] = w_v[k][15:8];
                w_a[3] = w_u[k][15:8];
                w_b[3] = w_v[k][7:0];
`endif
            end

            for (genvar m = 0; m < SUBP; m++) begin : g_m
                gf_mul_8 u_mul (.i_a(w_a[m]), .i_b(w_b[m]), .o_p(w_p8[k][m]));
            end

            gf_mul_8 u_cst (.i_a(r_p8[k][1]), .i_b(CST_GF2P16), .o_p(w_cm));

            // r1 = x1 ^ x2: schoolbook (a0b1^a1b0) ^ a1b1, Karatsuba mid ^ a0b0.
`ifdef GF_MUL_KARATSUBA_EN
            assign w_s2[k] = {r_p8[k][0], w_cm, r_p8[k][2], r_p8[k][0]};
`else
            assign w_s2[k] = {r_p8[k][0], w_cm, r_p8[k][2] ^ r_p8[k][3], r_p8[k][1]};
`endif
            assign w_s3[k] = {r_s2[k].x1 ^ r_s2[k].x2, r_s2[k].lo ^ r_s2[k].cm};
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_p8 <= '0;
                r_s2 <= '0;
                r_s3 <= '0;
            end else if (w_en) begin
                r_p8 <= w_p8;
                r_s2 <= w_s2;
                r_s3 <= w_s3;
            end
        end

        if (WIDTH == 16) begin : g_out16
            assign o_o = r_s3[0];
        end else begin : g_lvl32
            logic [7:0]  w_h20;
            logic [15:0] w_cm32;
            lvl32_t      w_s4;
            lvl32_t      r_s4;
            logic [31:0] r_s5;

            // C = {c1,0} with c1 = 0x20, times P11 = {h,l}:
            //   lo = 0x20 * (c1 * h), hi = c1 * (h ^ l)
            gf_mul_8 u_c0 (.i_a(r_s3[1][15:8]), .i_b(CST_GF2P32[15:8]), .o_p(w_h20));
            gf_mul_8 u_c1 (.i_a(w_h20), .i_b(CST_GF2P16), .o_p(w_cm32[7:0]));
            gf_mul_8 u_c2 (.i_a(r_s3[1][15:8] ^ r_s3[1][7:0]), .i_b(CST_GF2P32[15:8]),
                           .o_p(w_cm32[15:8]));

`ifdef GF_MUL_KARATSUBA_EN
            assign w_s4 = {r_s3[0], w_cm32, r_s3[2], r_s3[0]};
`else
            assign w_s4 = {r_s3[0], w_cm32, r_s3[2] ^ r_s3[3], r_s3[1]};
`endif

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_s4 <= '0;
                    r_s5 <= '0;
                end else if (w_en) begin
                    r_s4 <= w_s4;
                    r_s5 <= {r_s4.x1 ^ r_s4.x2, r_s4.lo ^ r_s4.cm};
                end
            end

            assign o_o = r_s5;
        end
    end

endmodule

// File: tb/tb_gf_mul_tower_pipe.sv
module tb_gf_mul_tower_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, iv, ir;
    logic [31:0] x, y;
    logic [3:0]  tag;
    logic [2:0]  ov, ordy;
    logic [7:0]  o8;
    logic [15:0] o16;
    logic [31:0] o32;
    logic [2:0][3:0]  ot;
    logic [2:0][31:0] oo;

    assign oo[0] = {24'h0, o8};
    assign oo[1] = {16'h0, o16};
    assign oo[2] = o32;

    gf_mul_tower_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_valid(iv), .o_ready(ordy[0]),
        .i_x(x[7:0]), .i_y(y[7:0]), .i_tag(tag), .o_valid(ov[0]),
        .i_ready(ir), .o_o(o8), .o_tag(ot[0]));

    gf_mul_tower_pipe #(.WIDTH(16), .TAG_W(4)) u_dut16 (
        .i_clk(clk), .i_rst(rst), .i_valid(iv), .o_ready(ordy[1]),
        .i_x(x[15:0]), .i_y(y[15:0]), .i_tag(tag), .o_valid(ov[1]),
        .i_ready(ir), .o_o(o16), .o_tag(ot[1]));

    gf_mul_tower_pipe #(.WIDTH(32), .TAG_W(4)) u_dut32 (
        .i_clk(clk), .i_rst(rst), .i_valid(iv), .o_ready(ordy[2]),
        .i_x(x), .i_y(y), .i_tag(tag), .o_valid(ov[2]),
        .i_ready(ir), .o_o(o32), .o_tag(ot[2]));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", nm, got, exp);
    endtask

    // Reference: field arithmetic straight from the tower definitions.
    function automatic logic [7:0] m8(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        logic [14:0] poly;
        p    = '0;
        poly = 15'h11B;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (poly << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [15:0] m16(input logic [15:0] a, input logic [15:0] b);
        logic [7:0] hh, ll, hl, lh;
        hh = m8(a[15:8], b[15:8]);
        ll = m8(a[7:0], b[7:0]);
        hl = m8(a[15:8], b[7:0]);
        lh = m8(a[7:0], b[15:8]);
        return {hl ^ lh ^ hh, ll ^ m8(8'h20, hh)};
    endfunction

    function automatic logic [31:0] m32(input logic [31:0] a, input logic [31:0] b);
        logic [15:0] hh, ll, hl, lh;
        hh = m16(a[31:16], b[31:16]);
        ll = m16(a[15:0], b[15:0]);
        hl = m16(a[31:16], b[15:0]);
        lh = m16(a[15:0], b[31:16]);
        return {hl ^ lh ^ hh, ll ^ m16(16'h2000, hh)};
    endfunction

    function automatic logic [31:0] ref_mul(input int k, input logic [31:0] a, input logic [31:0] b);
        case (k)
            0:       return {24'h0, m8(a[7:0], b[7:0])};
            1:       return {16'h0, m16(a[15:0], b[15:0])};
            default: return m32(a, b);
        endcase
    endfunction

    function automatic int lat_of(input int k);
        return 2 + 2 * k;
    endfunction

    typedef struct {
        logic [31:0] o;
        logic [3:0]  tag;
        int          cyc;
        int          stl;
    } exp_t;

    exp_t        sb [3][$];
    exp_t        e_m;
    int          cyc = 0;
    int          stl [3];
    logic        held [3];
    logic [31:0] hold_o [3];
    logic [3:0]  hold_t [3];

    initial for (int k = 0; k < 3; k++) begin
        stl[k]  = 0;
        held[k] = 1'b0;
    end

    // Scoreboard: transfers are resolved at negedge, where the handshake
    // seen is what the next rising edge will act on.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                sb[k].delete();
                held[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (held[k]) begin
                    chk($sformatf("hold_vld%0d", k), 32'(ov[k]), 32'd1);
                    chk($sformatf("hold_o%0d", k), oo[k], hold_o[k]);
                    chk($sformatf("hold_tag%0d", k), 32'(ot[k]), 32'(hold_t[k]));
                end
                if (ov[k] && ir) begin
                    if (sb[k].size() == 0) begin
                        chk($sformatf("ghost%0d", k), 32'(ov[k]), 32'd0);
                    end else begin
                        e_m = sb[k].pop_front();
                        chk($sformatf("o%0d", k), oo[k], e_m.o);
                        chk($sformatf("tag%0d", k), 32'(ot[k]), 32'(e_m.tag));
                        chk($sformatf("lat%0d", k), 32'(cyc - e_m.cyc),
                            32'(lat_of(k) + stl[k] - e_m.stl));
                    end
                end
                held[k]   = ov[k] && !ir;
                hold_o[k] = oo[k];
                hold_t[k] = ot[k];
                if (iv && ordy[k]) sb[k].push_back('{ref_mul(k, x, y), tag, cyc, stl[k]});
                if (ov[k] && !ir) stl[k]++;
            end
        end
        cyc++;
    end

    task automatic kat(input logic [31:0] a, input logic [31:0] b, input int k,
                       input logic [31:0] exp, input string nm);
        @(posedge clk); #1;
        iv = 1'b1; x = a; y = b; tag = 4'hA; ir = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        repeat (lat_of(k) - 1) @(posedge clk);
        @(negedge clk);
        chk({nm, "_vld"}, 32'(ov[k]), 32'd1);
        chk(nm, oo[k], exp);
    endtask

    task automatic drain_check(input string nm);
        @(posedge clk); #1;
        iv = 1'b0; ir = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s_left%0d", nm, k), 32'(sb[k].size()), 32'd0);
    endtask

    logic all_rdy;

    initial begin
        rst = 1'b1; iv = 1'b0; ir = 1'b1; x = '0; y = '0; tag = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_vld%0d", k), 32'(ov[k]), 32'd0);
            chk($sformatf("rst_rdy%0d", k), 32'(ordy[k]), 32'd1);
            chk($sformatf("rst_o%0d", k), oo[k], 32'd0);
            chk($sformatf("rst_tag%0d", k), 32'(ot[k]), 32'd0);
        end

        // Known answers, each checked exactly LAT cycles after accept.
        kat(32'h02, 32'h87, 0, 32'h15, "kat8_a");
        kat(32'h53, 32'hCA, 0, 32'h01, "kat8_b");
        kat(32'h0100, 32'h0100, 1, 32'h0120, "kat16_a");
        kat(32'h0001, 32'hBEEF, 1, 32'hBEEF, "kat16_b");
        kat(32'h0000, 32'h1234, 1, 32'h0000, "kat16_zero");
        kat(32'h00010000, 32'h00010000, 2, 32'h00012000, "kat32_a");
        drain_check("kat");

        // Tags 1,2,3 back-to-back on the 16-bit instance.
        @(posedge clk); #1;
        iv = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            tag = 4'(t); x = $urandom; y = $urandom;
            @(posedge clk); #1;
        end
        iv = 1'b0;
        @(posedge clk);
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            chk($sformatf("tag_order_v%0d", t), 32'(ov[1]), 32'd1);
            chk($sformatf("tag_order_t%0d", t), 32'(ot[1]), 32'(t));
        end
        drain_check("tags");

        // 1000 back-to-back random pairs, full throughput.
        @(posedge clk); #1;
        iv = 1'b1; ir = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            x = $urandom; y = $urandom; tag = tag + 4'd1;
            @(posedge clk); #1;
        end
        drain_check("stream");

        // Backpressure: continuous valid, 50% ready; operands held until all take them.
        @(posedge clk); #1;
        iv = 1'b1; x = $urandom; y = $urandom; tag = tag + 4'd1;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            all_rdy = &ordy;
            @(posedge clk); #1;
            if (all_rdy) begin
                x = $urandom; y = $urandom; tag = tag + 4'd1;
            end
            ir = 1'($urandom_range(0, 1));
        end
        drain_check("bp");

        // Reset with three products in flight and a valid input during reset.
        @(posedge clk); #1;
        ir = 1'b1; iv = 1'b1;
        for (int n = 0; n < 3; n++) begin
            x = $urandom; y = $urandom; tag = 4'(n + 5);
            @(posedge clk); #1;
        end
        x = $urandom; y = $urandom; tag = 4'hF;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; iv = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("mrst_vld%0d", k), 32'(ov[k]), 32'd0);
            chk($sformatf("mrst_rdy%0d", k), 32'(ordy[k]), 32'd1);
        end
        drain_check("mrst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
